nco_phase_gen: RTL

//  Phase accumulator stage directly upstream of nco_lut; produces the (WA+3)-bit phase word nco_lut decodes.

---
 rtl/nco_phase_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nco_phase_gen.sv
// Phase accumulator feeding nco_lut: constant tone or linear chirp, emitted
// as a valid/ready stream of (WA+3)-bit phase words.
module nco_phase_gen #(
   parameter int WA = 4,
   parameter int WP = 32,
   parameter int WC = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [WP-1:0] cfg_fcw,
   input  logic [WP-1:0] cfg_step,
   input  logic [WA+2:0] cfg_poff,
   input  logic [WC-1:0] cfg_count,
   output logic          phase_valid,
   input  logic          phase_ready,
   output logic [WA+2:0] phase,
   output logic          sweep_done
);

   localparam int WO = WA + 3;
   localparam logic [WC-1:0] CNT_ONE  = {{(WC-1){1'b0}}, 1'b1};
   localparam logic [WC-1:0] CNT_ZERO = {WC{1'b0}};
   localparam logic [WP-1:0] ACC_ZERO = {WP{1'b0}};
   localparam logic [WO-1:0] PH_ZERO  = {WO{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SWEEP = 2'd2
   } state_t;

   state_t        state_r;
   logic [WP-1:0] acc_r;
   logic [WP-1:0] fcw_r;
   logic [WP-1:0] step_r;
   logic [WO-1:0] poff_r;
   logic [WC-1:0] cnt_r;
   logic [WO-1:0] phase_r;
   logic          phase_valid_r;
   logic          sweep_done_r;

   logic          xfer_s;
   logic          cfg_acc_s;
   logic [WP-1:0] acc_next_s;

   // Output phase is the top WO accumulator bits plus the offset, modulo 2^WO.
   function automatic logic [WO-1:0] phase_of(input logic [WP-1:0] a, input logic [WO-1:0] off);
      return a[WP-1 -: WO] + off;
   endfunction

   assign cfg_ready   = (state_r != SWEEP);
   assign xfer_s      = phase_valid_r & phase_ready;
   assign cfg_acc_s   = cfg_valid & cfg_ready;
   assign acc_next_s  = acc_r + fcw_r;
   assign phase       = phase_r;
   assign phase_valid = phase_valid_r;
   assign sweep_done  = sweep_done_r;

   // Sequencer, accumulator, sweep counter and configuration registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         acc_r         <= ACC_ZERO;
         fcw_r         <= ACC_ZERO;
         step_r        <= ACC_ZERO;
         poff_r        <= PH_ZERO;
         cnt_r         <= CNT_ZERO;
         phase_r       <= PH_ZERO;
         phase_valid_r <= 1'b0;
         sweep_done_r  <= 1'b0;
      end else begin
         sweep_done_r <= 1'b0;
         // Accepted config lands next cycle; a concurrent transfer still sees the old words.
         if (cfg_acc_s) begin
            fcw_r  <= cfg_fcw;
            step_r <= cfg_step;
            poff_r <= cfg_poff;
            cnt_r  <= cfg_count;
         end
         if (!en) begin
            state_r       <= IDLE;
            phase_valid_r <= 1'b0;
            acc_r         <= ACC_ZERO;
         end else begin
            case (state_r)
               IDLE: begin
                  phase_r       <= phase_of(acc_r, poff_r);
                  phase_valid_r <= 1'b1;
                  state_r       <= (cnt_r != CNT_ZERO) ? SWEEP : RUN;
               end
               RUN: begin
                  if (xfer_s) begin
                     acc_r   <= acc_next_s;
                     phase_r <= phase_of(acc_next_s, poff_r);
                  end
                  if (cfg_acc_s && (cfg_count != CNT_ZERO)) begin
                     state_r <= SWEEP;
                  end
               end
               SWEEP: begin
                  if (xfer_s) begin
                     acc_r   <= acc_next_s;
                     phase_r <= phase_of(acc_next_s, poff_r);
                     fcw_r   <= fcw_r + step_r;
                     cnt_r   <= (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;
                     if (cnt_r <= CNT_ONE) begin
                        state_r      <= RUN;
                        sweep_done_r <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_r       <= IDLE;
                  phase_valid_r <= 1'b0;
                  acc_r         <= ACC_ZERO;
               end
            endcase
         end
      end
   end

endmodule
